// File: rtl/regfile_sync_param.sv
// Parametrised 2-read/1-write register file with registered reads, write-to-read bypass
// and an index-fill init sequencer that runs after reset or on init_req.
module regfile_sync_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr_wr,
    input  logic [WIDTH-1:0]  write_data,
    output logic [WIDTH-1:0]  read_data_a,
    output logic [WIDTH-1:0]  read_data_b,
    output logic              read_valid,
    output logic              ready
);

    localparam int unsigned      AW1     = ADDR_W + 1;
    // One extra bit so DEPTH == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0]  DepthW  = AW1'(DEPTH);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
    localparam bit               ZeroEn  = (ZERO_REG != 0);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic [WIDTH-1:0]  rd_a_q, rd_a_d;
    logic [WIDTH-1:0]  rd_b_q, rd_b_d;
    logic              rd_valid_q, rd_valid_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              run;
    logic              wr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    function automatic logic addr_blank(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} >= DepthW) || (ZeroEn && (addr == '0));
    endfunction

    function automatic logic [WIDTH-1:0] rd_sel(input logic [ADDR_W-1:0] addr,
                                                input logic [WIDTH-1:0]  mem_word);
        logic [WIDTH-1:0] val;
        val = mem_word;
        if (addr_blank(addr)) begin
            val = '0;
        end else if (wr_ok && (addr_wr == addr)) begin
            val = write_data;
        end
        return val;
    endfunction

    assign run   = (state_q == StRun);
    assign wr_ok = run && wr_en && !addr_blank(addr_wr);

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_wr;
        mem_wdata  = write_data;
        unique case (state_q)
            StInit: begin
                mem_we     = 1'b1;
                mem_waddr  = init_ptr_q;
                mem_wdata  = (ZeroEn && (init_ptr_q == '0)) ? '0 : WIDTH'(init_ptr_q);
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LastIdx) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                mem_we = wr_ok;
                if (init_req) begin
                    state_d    = StInit;
                    init_ptr_d = '0;
                end
            end
            default: begin
                state_d    = StInit;
                init_ptr_d = '0;
            end
        endcase
    end

    always_comb begin
        rd_a_d     = rd_a_q;
        rd_b_d     = rd_b_q;
        rd_valid_d = 1'b0;
        if (run && rd_en) begin
            rd_a_d     = rd_sel(addr_a, mem_q[addr_a]);
            rd_b_d     = rd_sel(addr_b, mem_q[addr_b]);
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_ptr_q <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage has no reset; the init sequencer rewrites every entry.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign read_data_a = rd_a_q;
    assign read_data_b = rd_b_q;
    assign read_valid  = rd_valid_q;
    assign ready       = run;

endmodule
